// File: rtl/simplerisc_pkg.sv
// Shared definitions for the simplerisc pipeline: EXT tracker states and default widths.
package simplerisc_pkg;

    localparam int DEF_REG_W       = 5;
    localparam int DEF_EXT_LATENCY = 4;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT_RUN = 2'd1,
        EXT_WB  = 2'd2
    } ext_state_e;

endpackage

// File: rtl/hazard_control_unit_ext_tracker.sv
// Tracks the single in-flight multicycle EXT op: state, latency countdown, and destination register.
module ext_tracker
    import simplerisc_pkg::*;
#(
    parameter int EXT_LATENCY = DEF_EXT_LATENCY,
    parameter int REG_W       = DEF_REG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ext_issue,
    input  logic [REG_W-1:0] rd_id,
    output ext_state_e       state,
    output logic [REG_W-1:0] ext_rd_q,
    output logic [REG_W-1:0] rd_ext,
    output logic             ext_busy
);

    // Issue cycle plus EXT_RUN cycles (CNT_LOAD..0) lands the result in EXT_WB exactly EXT_LATENCY later.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXT_LATENCY - 2);

    ext_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REG_W-1:0] rd_q, rd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (ext_issue) begin
                    state_d = EXT_RUN;
                    cnt_d   = CNT_LOAD;
                    rd_d    = rd_id;
                end
            end
            EXT_RUN: begin
                if (cnt_q == '0) state_d = EXT_WB;
                else             cnt_d   = cnt_q - 1'b1;
            end
            EXT_WB: begin
                if (ext_issue) begin
                    state_d = EXT_RUN;
                    cnt_d   = CNT_LOAD;
                    rd_d    = rd_id;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state    = state_q;
    assign ext_rd_q = rd_q;
    assign rd_ext   = (state_q == EXT_WB) ? rd_q : '0;
    assign ext_busy = (state_q != IDLE);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use and EXT RAW/WAW/structural stalls, branch flush.
// Optional HAZARD_PERF_CNT_EN adds a saturating 32-bit stall_cycles counter port.
module hazard_control_unit
    import simplerisc_pkg::*;
#(
    parameter int EXT_LATENCY = DEF_EXT_LATENCY,
    parameter int REG_W       = DEF_REG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_id,
    input  logic [REG_W-1:0] rp1_id,
    input  logic [REG_W-1:0] rp2_id,
    input  logic             use_rp1_id,
    input  logic             use_rp2_id,
    input  logic [REG_W-1:0] rd_id,
    input  logic             is_ext_id,
    input  logic             is_load_alu,
    input  logic [REG_W-1:0] rd_alu,
    input  logic             branch_taken_alu,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_alu,
    output logic             flush_id,
    output logic             ext_issue,
    output logic             ext_busy,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]      stall_cycles,
`endif
    output logic [REG_W-1:0] rd_ext
);

    ext_state_e       state;
    logic [REG_W-1:0] ext_rd_q;
    logic             load_use, ext_raw, ext_waw, ext_struct, stall;
    logic             src_hit_alu, src_hit_ext, ext_running;

    ext_tracker #(
        .EXT_LATENCY (EXT_LATENCY),
        .REG_W       (REG_W)
    ) u_ext_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .ext_issue (ext_issue),
        .rd_id     (rd_id),
        .state     (state),
        .ext_rd_q  (ext_rd_q),
        .rd_ext    (rd_ext),
        .ext_busy  (ext_busy)
    );

    assign src_hit_alu = (use_rp1_id && rp1_id == rd_alu) || (use_rp2_id && rp2_id == rd_alu);
    assign src_hit_ext = (use_rp1_id && rp1_id == ext_rd_q) || (use_rp2_id && rp2_id == ext_rd_q);
    assign ext_running = valid_id && (state == EXT_RUN);

    assign load_use   = valid_id && is_load_alu && (rd_alu != '0) && src_hit_alu;
    assign ext_raw    = ext_running && (ext_rd_q != '0) && src_hit_ext;
    assign ext_waw    = ext_running && (rd_id != '0) && (rd_id == ext_rd_q);
    assign ext_struct = ext_running && is_ext_id;
    assign stall      = load_use || ext_raw || ext_waw || ext_struct;

    // A taken branch squashes decode, so its stall request is moot.
    assign flush_id   = branch_taken_alu;
    assign stall_if   = stall && !branch_taken_alu;
    assign stall_id   = stall && !branch_taken_alu;
    assign bubble_alu = stall || branch_taken_alu;
    assign ext_issue  = valid_id && is_ext_id && !stall && !branch_taken_alu;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (stall && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter EXT_LATENCY, default 4, cycles from EXT issue to EXT result valid (legal 2..15).
REQ-002 Parameter REG_W, default 5, register index width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 valid_id  in  1  decode-stage instruction valid.
REQ-006 rp1_id, rp2_id  in  REG_W  decode-stage source registers.
REQ-007 use_rp1_id, use_rp2_id  in  1  source actually read.
REQ-008 rd_id  in  REG_W  decode-stage destination; 0 = no write.
REQ-009 is_ext_id  in  1  decode-stage instruction is multicycle EXT op.
REQ-010 is_load_alu  in  1  ALU-stage instruction is a load.
REQ-011 rd_alu  in  REG_W  ALU-stage destination.
REQ-012 branch_taken_alu  in  1  ALU-stage branch resolved taken.
REQ-013 stall_if, stall_id  out  1  hold PC and IF/ID register.
REQ-014 bubble_alu  out  1  inject NOP into ID/ALU register.
REQ-015 flush_id  out  1  squash IF/ID contents.
REQ-016 ext_issue  out  1  EXT op accepted this cycle.
REQ-017 ext_busy  out  1  EXT unit occupied.
REQ-018 rd_ext  out  REG_W  destination of EXT result, feeds forwarding rd_EXT; 0 when no result valid.

Function
REQ-019 FSM states IDLE, EXT_RUN, EXT_WB; reset state IDLE.
REQ-020 IDLE->EXT_RUN when ext_issue; counter loads EXT_LATENCY-2, ext_rd_q captures rd_id.
REQ-021 EXT_RUN: counter decrements each cycle; at counter 0 go EXT_WB.
REQ-022 EXT_WB lasts exactly one cycle, rd_ext=ext_rd_q, then IDLE, or EXT_RUN if a new ext_issue occurs that cycle.
REQ-023 rd_ext SHALL be 0 in IDLE and EXT_RUN; ext_busy=1 in EXT_RUN and EXT_WB.
REQ-024 load_use = valid_id & is_load_alu & rd_alu!=0 & ((use_rp1_id & rp1_id==rd_alu) | (use_rp2_id & rp2_id==rd_alu)).
REQ-025 ext_raw = valid_id & state==EXT_RUN & ext_rd_q!=0 & source match on ext_rd_q as in REQ-024.
REQ-026 ext_waw = valid_id & state==EXT_RUN & rd_id!=0 & rd_id==ext_rd_q.
REQ-027 ext_struct = valid_id & is_ext_id & state==EXT_RUN.
REQ-028 stall = load_use | ext_raw | ext_waw | ext_struct; stall drives stall_if, stall_id, bubble_alu.
REQ-029 branch_taken_alu SHALL force flush_id=1, bubble_alu=1, stall_if=stall_id=0 (flush overrides stall).
REQ-030 ext_issue = valid_id & is_ext_id & !stall & !branch_taken_alu, legal in IDLE or EXT_WB.
REQ-031 Stall/flush outputs combinational from inputs and registered state; zero-cycle latency.
REQ-032 Load-use stall lasts one cycle; EXT stalls persist until EXT_WB, where forwarding of result_EXT resolves RAW.

Reset
REQ-033 rst_n low at any time, including mid EXT_RUN: state=IDLE, counter=0, ext_rd_q=0, in-flight EXT result discarded, rd_ext=0, ext_busy=0.
REQ-034 Reset-asserted outputs driven only by combinational input terms; bench drives valid_id=0 during reset.

Configuration
REQ-035 Macro HAZARD_PERF_CNT_EN defined: add output stall_cycles (32 bits), incremented each cycle stall=1, saturating at 0xFFFFFFFF, cleared by reset.
REQ-036 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-037 Shared package simplerisc_pkg: FSM state enum, REG_W, default EXT_LATENCY.
REQ-038 One sub-module ext_tracker: FSM, counter, ext_rd_q; hazard equations remain in top.

Verification
REQ-039 Load r3 in ALU, decode reads r3 -> stall_if/stall_id/bubble_alu high exactly 1 cycle.
REQ-040 EXT to r5 issued, next instruction reads r5 -> stalls 3 cycles (EXT_LATENCY=4), rd_ext=5 in EXT_WB cycle only.
REQ-041 Back-to-back EXT ops -> second stalls until EXT_WB, issues in that cycle, FSM returns to EXT_RUN.
REQ-042 Taken branch coincident with load-use -> flush_id=1, bubble_alu=1, stall_if=0, no ext_issue.
REQ-043 rst_n low during EXT_RUN counter=1 -> IDLE immediately, rd_ext never shows captured register.
REQ-044 rd_alu=0 load, decode reads r0 -> no stall.
